// File: rtl/gfx_pkg.sv
// Shared fixed-point vertex types and helpers for the triangle setup path.
package gfx_pkg;

  localparam int unsigned FRAC_BITS = 4;
  localparam int unsigned AREA_W    = 35;

  localparam int unsigned VX = 0;
  localparam int unsigned VY = 1;
  localparam int unsigned VZ = 2;

  typedef logic signed [15:0]       vfixed_t;
  typedef vfixed_t [2:0]            vertex_t;
  typedef logic signed [16:0]       vdelta_t;
  typedef logic signed [33:0]       vprod_t;
  typedef logic signed [AREA_W-1:0] area_t;

  function automatic vdelta_t vsub(input vfixed_t a, input vfixed_t b);
    return vdelta_t'(a) - vdelta_t'(b);
  endfunction

  function automatic vfixed_t vmin3(input vfixed_t a, input vfixed_t b, input vfixed_t c);
    vfixed_t m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic vfixed_t vmax3(input vfixed_t a, input vfixed_t b, input vfixed_t c);
    vfixed_t m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

endpackage

// File: rtl/bbox_clamp.sv
// One-axis bounding-box conversion: Q12.4 raw extent to clamped pixel range,
// plus a flag when the extent lies wholly outside the screen on this axis.
module bbox_clamp
  import gfx_pkg::*;
#(
  parameter int unsigned SCREEN_SIZE = 320,
  parameter int unsigned OUT_W       = $clog2(SCREEN_SIZE)
) (
  input  vfixed_t          raw_min,
  input  vfixed_t          raw_max,
  output logic [OUT_W-1:0] pix_min,
  output logic [OUT_W-1:0] pix_max,
  output logic             offscreen
);

  localparam int LIMIT     = int'(SCREEN_SIZE) - 1;
  localparam int RAW_LIMIT = int'(SCREEN_SIZE) << FRAC_BITS;

  // Arithmetic shift floors toward negative infinity before clamping.
  function automatic logic [OUT_W-1:0] clamp_pix(input vfixed_t raw);
    int pix;
    pix = int'(raw) >>> FRAC_BITS;
    if (pix < 0) return '0;
    if (pix > LIMIT) return OUT_W'(LIMIT);
    return OUT_W'(pix);
  endfunction

  always_comb begin
    pix_min   = clamp_pix(raw_min);
    pix_max   = clamp_pix(raw_max);
    offscreen = (raw_max < 0) || (int'(raw_min) >= RAW_LIMIT);
  end

endmodule

// File: rtl/tri_setup.sv
// Three-stage triangle setup: edge deltas, cross products and bbox, then
// signed area with cull decision. Culled triangles vanish without stalling.
module tri_setup
  import gfx_pkg::*;
#(
  parameter int unsigned MAX_COUNT     = 1024,
  parameter int unsigned SCREEN_W      = 320,
  parameter int unsigned SCREEN_H      = 180,
  parameter bit          CULL_BACKFACE = 1'b1,
  localparam int unsigned ID_W = $clog2(MAX_COUNT),
  localparam int unsigned XW   = $clog2(SCREEN_W),
  localparam int unsigned YW   = $clog2(SCREEN_H)
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  vertex_t [2:0]      tri_vertices_in,
  input  logic [ID_W-1:0]    tri_id_in,
  input  logic               tri_valid_in,
  output logic               tri_ready_out,
  output vertex_t [2:0]      tri_vertices_out,
  output logic [ID_W-1:0]    tri_id_out,
  output area_t              area_out,
  output logic [XW-1:0]      bbox_xmin_out,
  output logic [XW-1:0]      bbox_xmax_out,
  output logic [YW-1:0]      bbox_ymin_out,
  output logic [YW-1:0]      bbox_ymax_out,
  output logic               valid_out,
  input  logic               ready_in,
  output logic [15:0]        cull_count_out
);

  logic stall;
  logic advance;

  assign stall         = valid_out && !ready_in;
  assign advance       = !stall;
  assign tri_ready_out = advance;

  logic            s1_valid;
  logic [ID_W-1:0] s1_id;
  vertex_t [2:0]   s1_vtx;
  vdelta_t         s1_dx1, s1_dy1, s1_dx2, s1_dy2;
  vfixed_t         s1_xmin, s1_xmax, s1_ymin, s1_ymax;

  logic            s2_valid;
  logic [ID_W-1:0] s2_id;
  vertex_t [2:0]   s2_vtx;
  vprod_t          s2_p1, s2_p2;
  logic [XW-1:0]   s2_xmin, s2_xmax;
  logic [YW-1:0]   s2_ymin, s2_ymax;
  logic            s2_offscreen;

  logic [XW-1:0]   bx_min, bx_max;
  logic [YW-1:0]   by_min, by_max;
  logic            off_x, off_y;

  area_t           area;
  logic            cull;

  bbox_clamp #(.SCREEN_SIZE(SCREEN_W), .OUT_W(XW)) u_clamp_x (
    .raw_min   (s1_xmin),
    .raw_max   (s1_xmax),
    .pix_min   (bx_min),
    .pix_max   (bx_max),
    .offscreen (off_x)
  );

  bbox_clamp #(.SCREEN_SIZE(SCREEN_H), .OUT_W(YW)) u_clamp_y (
    .raw_min   (s1_ymin),
    .raw_max   (s1_ymax),
    .pix_min   (by_min),
    .pix_max   (by_max),
    .offscreen (off_y)
  );

  always_comb begin
    area = area_t'(s2_p1) - area_t'(s2_p2);
    cull = (area == '0) || s2_offscreen || (CULL_BACKFACE && (area < 0));
  end

  // Control path: the whole pipe freezes on stall, including bubbles.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s1_valid       <= 1'b0;
      s2_valid       <= 1'b0;
      valid_out      <= 1'b0;
      cull_count_out <= '0;
    end else if (advance) begin
      s1_valid  <= tri_valid_in;
      s2_valid  <= s1_valid;
      valid_out <= s2_valid && !cull;
      if (s2_valid && cull && (cull_count_out != '1))
        cull_count_out <= cull_count_out + 16'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (advance) begin
      s1_id   <= tri_id_in;
      s1_vtx  <= tri_vertices_in;
      s1_dx1  <= vsub(tri_vertices_in[1][VX], tri_vertices_in[0][VX]);
      s1_dy1  <= vsub(tri_vertices_in[1][VY], tri_vertices_in[0][VY]);
      s1_dx2  <= vsub(tri_vertices_in[2][VX], tri_vertices_in[0][VX]);
      s1_dy2  <= vsub(tri_vertices_in[2][VY], tri_vertices_in[0][VY]);
      s1_xmin <= vmin3(tri_vertices_in[0][VX], tri_vertices_in[1][VX], tri_vertices_in[2][VX]);
      s1_xmax <= vmax3(tri_vertices_in[0][VX], tri_vertices_in[1][VX], tri_vertices_in[2][VX]);
      s1_ymin <= vmin3(tri_vertices_in[0][VY], tri_vertices_in[1][VY], tri_vertices_in[2][VY]);
      s1_ymax <= vmax3(tri_vertices_in[0][VY], tri_vertices_in[1][VY], tri_vertices_in[2][VY]);

      s2_id        <= s1_id;
      s2_vtx       <= s1_vtx;
      s2_p1        <= s1_dx1 * s1_dy2;
      s2_p2        <= s1_dx2 * s1_dy1;
      s2_xmin      <= bx_min;
      s2_xmax      <= bx_max;
      s2_ymin      <= by_min;
      s2_ymax      <= by_max;
      s2_offscreen <= off_x || off_y;

      tri_id_out       <= s2_id;
      tri_vertices_out <= s2_vtx;
      area_out         <= area;
      bbox_xmin_out    <= s2_xmin;
      bbox_xmax_out    <= s2_xmax;
      bbox_ymin_out    <= s2_ymin;
      bbox_ymax_out    <= s2_ymax;
    end
  end

endmodule

// File: tb/tb_tri_setup.sv
// Scoreboard bench for tri_setup: directed triangles, stall, reset and
// cull-counter saturation, with a second instance that keeps back faces.
module tb_tri_setup;
  import gfx_pkg::*;

  localparam int unsigned ID_W = 10;
  localparam int unsigned XW   = 9;
  localparam int unsigned YW   = 8;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_in = ~clk_in;

  vertex_t [2:0]   tri_vertices_in = '0;
  logic [ID_W-1:0] tri_id_in = '0;
  logic            tri_valid_in = 1'b0;
  logic            ready_in = 1'b1;

  logic            tri_ready_out;
  vertex_t [2:0]   tri_vertices_out;
  logic [ID_W-1:0] tri_id_out;
  logic [AREA_W-1:0] area_out;
  logic [XW-1:0]   bbox_xmin_out, bbox_xmax_out;
  logic [YW-1:0]   bbox_ymin_out, bbox_ymax_out;
  logic            valid_out;
  logic [15:0]     cull_count_out;

  logic            nc_valid_in;
  logic            nc_ready_in = 1'b1;
  logic            nc_ready_out;
  vertex_t [2:0]   nc_vertices_out;
  logic [ID_W-1:0] nc_id_out;
  logic [AREA_W-1:0] nc_area_out;
  logic [XW-1:0]   nc_xmin, nc_xmax;
  logic [YW-1:0]   nc_ymin, nc_ymax;
  logic            nc_valid_out;
  logic [15:0]     nc_cull_count;

  assign nc_valid_in = tri_valid_in && tri_ready_out;

  tri_setup dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .tri_vertices_in  (tri_vertices_in),
    .tri_id_in        (tri_id_in),
    .tri_valid_in     (tri_valid_in),
    .tri_ready_out    (tri_ready_out),
    .tri_vertices_out (tri_vertices_out),
    .tri_id_out       (tri_id_out),
    .area_out         (area_out),
    .bbox_xmin_out    (bbox_xmin_out),
    .bbox_xmax_out    (bbox_xmax_out),
    .bbox_ymin_out    (bbox_ymin_out),
    .bbox_ymax_out    (bbox_ymax_out),
    .valid_out        (valid_out),
    .ready_in         (ready_in),
    .cull_count_out   (cull_count_out)
  );

  tri_setup #(.CULL_BACKFACE(1'b0)) dut_nc (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .tri_vertices_in  (tri_vertices_in),
    .tri_id_in        (tri_id_in),
    .tri_valid_in     (nc_valid_in),
    .tri_ready_out    (nc_ready_out),
    .tri_vertices_out (nc_vertices_out),
    .tri_id_out       (nc_id_out),
    .area_out         (nc_area_out),
    .bbox_xmin_out    (nc_xmin),
    .bbox_xmax_out    (nc_xmax),
    .bbox_ymin_out    (nc_ymin),
    .bbox_ymax_out    (nc_ymax),
    .valid_out        (nc_valid_out),
    .ready_in         (nc_ready_in),
    .cull_count_out   (nc_cull_count)
  );

  typedef struct {
    logic [ID_W-1:0]   id;
    logic [AREA_W-1:0] area;
    logic [XW-1:0]     xmin, xmax;
    logic [YW-1:0]     ymin, ymax;
    vertex_t [2:0]     vtx;
    bit                lat;
    int                acc;
  } exp_t;

  exp_t q_main[$];
  exp_t q_nc[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_culls = 0;
  bit stall_trigger = 1'b0;

  always @(negedge clk_in) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s: output with empty scoreboard (t=%0t)", name, $time);
  endtask

  initial begin : mon_main
    exp_t e;
    forever begin
      @(negedge clk_in); #2;
      if (rst_in && valid_out && ready_in) begin
        if (q_main.size() == 0) unexpected("main_out");
        else begin
          e = q_main.pop_front();
          chk("id", 64'(tri_id_out), 64'(e.id));
          chk("area", 64'(area_out), 64'(e.area));
          chk("bbox_x", {32'(bbox_xmin_out), 32'(bbox_xmax_out)}, {32'(e.xmin), 32'(e.xmax)});
          chk("bbox_y", {32'(bbox_ymin_out), 32'(bbox_ymax_out)}, {32'(e.ymin), 32'(e.ymax)});
          for (int i = 0; i < 3; i++) chk("vertex", 64'(tri_vertices_out[i]), 64'(e.vtx[i]));
          if (e.lat) chk("latency", 64'(cyc - e.acc), 64'd3);
        end
      end
    end
  end

  initial begin : mon_nc
    exp_t e;
    forever begin
      @(negedge clk_in); #2;
      if (rst_in && nc_valid_out) begin
        if (q_nc.size() == 0) unexpected("nc_out");
        else begin
          e = q_nc.pop_front();
          chk("nc_id", 64'(nc_id_out), 64'(e.id));
          chk("nc_area", 64'(nc_area_out), 64'(e.area));
        end
      end
    end
  end

  initial begin : stall_gen
    wait (stall_trigger);
    repeat (4) begin
      @(negedge clk_in);
      ready_in = 1'b0;
      #1;
      chk("stall_ready", 64'(tri_ready_out), 64'd0);
      chk("stall_valid", 64'(valid_out), 64'd1);
    end
    @(negedge clk_in);
    ready_in = 1'b1;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input int id, input int x0, input int y0, input int x1, input int y1,
                      input int x2, input int y2, input bit em, input bit em_nc,
                      input longint area, input int xmn, input int xmx, input int ymn,
                      input int ymx, input bit lat);
    exp_t e;
    vertex_t [2:0] v;
    int waitc;
    v[0][VX] = 16'(x0); v[0][VY] = 16'(y0);
    v[1][VX] = 16'(x1); v[1][VY] = 16'(y1);
    v[2][VX] = 16'(x2); v[2][VY] = 16'(y2);
    for (int i = 0; i < 3; i++) v[i][VZ] = 16'(id * 4 + i);
    @(negedge clk_in);
    tri_vertices_in = v;
    tri_id_in       = ID_W'(id);
    tri_valid_in    = 1'b1;
    #1;
    waitc = 0;
    while (!tri_ready_out && waitc < 200) begin
      @(negedge clk_in); #1;
      waitc++;
    end
    if (!tri_ready_out) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: id %0d never accepted", id);
      tri_valid_in = 1'b0;
      return;
    end
    e.id = ID_W'(id); e.area = AREA_W'(area);
    e.xmin = XW'(xmn); e.xmax = XW'(xmx); e.ymin = YW'(ymn); e.ymax = YW'(ymx);
    e.vtx = v; e.lat = lat; e.acc = cyc;
    if (em) q_main.push_back(e);
    else if (exp_culls < 65535) exp_culls++;
    if (em_nc) q_nc.push_back(e);
    @(posedge clk_in);
  endtask

  task automatic drain(input int n);
    @(negedge clk_in);
    tri_valid_in = 1'b0;
    repeat (n) @(negedge clk_in);
    #3;
    chk("main_drained", 64'(q_main.size()), 64'd0);
    chk("nc_drained", 64'(q_nc.size()), 64'd0);
    chk("cull_count", 64'(cull_count_out), 64'(exp_culls));
  endtask

  initial begin : driver
    repeat (3) @(negedge clk_in);
    #1;
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_cull", 64'(cull_count_out), 64'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    chk("rst_ready", 64'(tri_ready_out), 64'd1);

    send(1, 0, 0, 16, 0, 0, 16, 1, 1, 256, 0, 1, 0, 1, 1);
    drain(6);
    send(2, 0, 0, 0, 16, 16, 0, 0, 1, -256, 0, 1, 0, 1, 0);
    drain(6);
    send(3, 0, 0, 16, 16, 32, 32, 0, 0, 0, 0, 0, 0, 0, 0);
    send(4, -12800, 0, -1600, 0, -12800, 1600, 0, 0, 0, 0, 0, 0, 0, 0);
    send(5, 0, 2880, 16, 2880, 0, 2896, 0, 0, 0, 0, 0, 0, 0, 0);
    send(6, -160, -160, 8000, -160, -160, 5000, 1, 1, 42105600, 0, 319, 0, 179, 0);
    send(7, 40, 50, 200, 60, 100, 300, 1, 1, 39400, 2, 12, 3, 18, 0);
    send(8, 0, 2879, 16, 2879, 0, 2895, 1, 1, 256, 0, 1, 179, 179, 0);
    send(9, -32768, -32768, 32767, -32768, -32768, 32767, 1, 1, 64'd4294836225, 0, 319, 0, 179, 0);
    drain(8);

    for (int k = 0; k < 10; k++) begin
      send(100 + k, 16 * k, 0, 16 * k + 16, 0, 16 * k, 16, 1, 1, 256, k, k + 1, 0, 1, 0);
      if (k == 5) stall_trigger = 1'b1;
    end
    drain(10);

    // Two live triangles plus a culled one still in stage 1 when reset hits.
    send(200, 0, 0, 16, 0, 0, 16, 1, 1, 256, 0, 1, 0, 1, 0);
    send(201, 0, 0, 16, 0, 0, 16, 1, 1, 256, 0, 1, 0, 1, 0);
    send(202, 0, 0, 16, 16, 32, 32, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_in);
    tri_valid_in = 1'b0;
    rst_in = 1'b0;
    q_main.delete();
    q_nc.delete();
    exp_culls = 0;
    #1;
    chk("midrst_valid", 64'(valid_out), 64'd0);
    chk("midrst_nc_valid", 64'(nc_valid_out), 64'd0);
    chk("midrst_cull", 64'(cull_count_out), 64'd0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    drain(10);
    chk("post_rst_ready", 64'(tri_ready_out), 64'd1);

    for (int k = 0; k < 65534; k++) send(k % 1024, 0, 0, 16, 16, 32, 32, 0, 0, 0, 0, 0, 0, 0, 0);
    drain(6);
    for (int k = 0; k < 3; k++) send(k, 0, 0, 16, 16, 32, 32, 0, 0, 0, 0, 0, 0, 0, 0);
    drain(6);
    chk("cull_saturated", 64'(cull_count_out), 64'h0000_0000_0000_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tri_setup.md
TRI_SETUP -- requirements
Module: tri_setup

Interface
REQ-001 Parameter MAX_COUNT, default 1024, triangle-id range; id width = $clog2(MAX_COUNT).
REQ-002 Parameter SCREEN_W, default 320, screen width in pixels.
REQ-003 Parameter SCREEN_H, default 180, screen height in pixels.
REQ-004 Parameter CULL_BACKFACE, default 1, enables culling of negative-area triangles.
REQ-005 clk_in  input  1  single system clock, all logic on rising edge.
REQ-006 rst_in  input  1  asynchronous, active-low reset.
REQ-007 tri_vertices_in  input  3 x vertex_t  triangle; per vertex [0]=x, [1]=y, [2]=z; x,y are signed Q12.4 screen coordinates.
REQ-008 tri_id_in  input  $clog2(MAX_COUNT)  triangle index.
REQ-009 tri_valid_in  input  1  input triangle valid.
REQ-010 tri_ready_out  output  1  block accepts the input this cycle.
REQ-011 tri_vertices_out  output  3 x vertex_t  accepted vertices, passed through unchanged.
REQ-012 tri_id_out  output  $clog2(MAX_COUNT)  id of the output triangle.
REQ-013 area_out  output  35 signed  twice the signed screen area.
REQ-014 bbox_xmin_out, bbox_xmax_out  output  $clog2(SCREEN_W) each  clamped pixel x bounds.
REQ-015 bbox_ymin_out, bbox_ymax_out  output  $clog2(SCREEN_H) each  clamped pixel y bounds.
REQ-016 valid_out  output  1  output triangle valid.
REQ-017 ready_in  input  1  downstream accepts the output.
REQ-018 cull_count_out  output  16  number of dropped triangles, saturating.

Function
REQ-019 Input transfer occurs when tri_valid_in && tri_ready_out; output transfer occurs when valid_out && ready_in.
REQ-020 Pipeline has 3 register stages; a triangle accepted in cycle N presents on valid_out in cycle N+3 when no stall occurs.
REQ-021 stall = valid_out && !ready_in; while stall is high, all stages hold and tri_ready_out = 0; otherwise tri_ready_out = 1.
REQ-022 While valid_out is high, outputs are held stable until the output transfer completes.
REQ-023 S1 registers the edge differences dx1 = x1-x0, dy1 = y1-y0, dx2 = x2-x0, dy2 = y2-y0 at 17-bit signed, plus raw min/max of x and of y.
REQ-024 S2 registers the 34-bit signed products dx1*dy2 and dx2*dy1, and the bbox: arithmetic shift right by 4 (floor), clamped to [0,SCREEN_W-1] and [0,SCREEN_H-1].
REQ-025 S2 also flags the triangle offscreen when raw max < 0 or raw min >= screen size on either axis.
REQ-026 S3: area = dx1*dy2 - dx2*dy1, computed at 35 bits with no overflow.
REQ-027 S3 culls the triangle when area == 0, OR offscreen, OR (CULL_BACKFACE && area < 0).
REQ-028 A culled triangle never asserts valid_out and does not cause a stall; it increments cull_count_out, which saturates at 16'hFFFF.
REQ-029 Counter-clockwise winding (area > 0) is front-facing.
REQ-030 Back-to-back inputs sustain 1 triangle per cycle when ready_in is held high.

Reset
REQ-031 When rst_in = 0, asynchronously clear all stage valid bits, valid_out, and cull_count_out to 0.
REQ-032 During reset, data registers are don't-care; after reset tri_ready_out = 1.
REQ-033 Reset mid-operation discards all in-flight triangles without emitting or counting them.

Structure
REQ-034 vfixed_t and vertex_t, the Q-format fractional-bit constant (4), and the area width (35) shall live in a shared package, gfx_pkg.
REQ-035 The three pipeline stages are inline; a single sub-module, bbox_clamp (shift, clamp and offscreen flag for one axis), is instantiated once per axis.

Verification
REQ-036 Input vertices (0,0),(16,0),(0,16) in raw Q12.4 with ready_in = 1 -> valid_out at +3 cycles, area_out = 256, bbox x 0..1, y 0..1.
REQ-037 Same triangle with v1 and v2 swapped -> area_out = -256; culled when CULL_BACKFACE = 1, cull_count_out increments by 1, and it is emitted when CULL_BACKFACE = 0.
REQ-038 Collinear vertices (0,0),(16,16),(32,32) -> culled; triangle at x in -800..-100 -> culled as offscreen.
REQ-039 Vertices spanning (-160,-160) to (8000,5000) -> bbox clamped to 0..319, 0..179.
REQ-040 Stream of 10 triangles with ready_in low for 4 cycles mid-stream -> tri_ready_out = 0 during the stall, no loss or duplication, ids in order.
REQ-041 Assert rst_in low with 3 triangles in flight -> valid_out = 0 immediately; no stale output after release; cull_count_out saturates after 65535 culled triangles.
